// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

    // Receiver FSM states.
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } uart_rx_state_e;

    // Parity modes accepted by the PARITY_BIT parameter.
    localparam string PARITY_NONE = "none";
    localparam string PARITY_EVEN = "even";
    localparam string PARITY_ODD  = "odd";

    // Expected line value of the parity bit given the XOR of the data bits.
    function automatic logic parity_expected(input logic data_xor, input logic odd_mode);
        return data_xor ^ odd_mode;
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchroniser, bit-phase counter and 2-of-3 majority voter.
// The strobe marks the decision phase MID+1; sample_bit is valid during it.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    input  logic restart,
    output logic rx_sync,
    output logic sample_stb,
    output logic sample_bit,
    output logic phase_wrap
);

    localparam int MID = CLKS_PER_BIT / 2;
    localparam int PW  = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [PW-1:0] PH_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PH_A    = PW'(MID - 1);
    localparam logic [PW-1:0] PH_B    = PW'(MID);
    localparam logic [PW-1:0] PH_C    = PW'(MID + 1);

    logic          rx_meta;
    logic [PW-1:0] phase;
    logic          smp_a;
    logic          smp_b;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running bit-phase counter, realigned to 0 when a start bit begins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (restart || phase == PH_LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

    // Capture the first two of the three mid-bit samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_a <= 1'b0;
            smp_b <= 1'b0;
        end else begin
            if (phase == PH_A) smp_a <= rx_sync;
            if (phase == PH_B) smp_b <= rx_sync;
        end
    end

    assign sample_stb = (phase == PH_C);
    assign sample_bit = (smp_a & smp_b) | (smp_a & rx_sync) | (smp_b & rx_sync);
    assign phase_wrap = (phase == PH_LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with parity, framing, overrun and break
// detection and a valid/ready holding register.
//
// state         | meaning
// --------------+-----------------------------------------------------
// ST_IDLE       | line idle, waiting for a low level (after line seen high)
// ST_START      | validating the start bit at mid-bit
// ST_DATA       | shifting in data bits, LSB first
// ST_PARITY     | sampling and checking the parity bit
// ST_STOP       | sampling stop bits; frame resolved at the last one
// ST_BREAK_WAIT | break seen, waiting for one full bit time of high line
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int    DATA_BITS    = 8,
    parameter string PARITY_BIT   = "none",
    parameter int    STOP_BITS    = 1,
    parameter int    CLKS_PER_BIT = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 err_parity,
    output logic                 err_frame,
    output logic                 err_overrun,
    output logic                 rx_break,
    output logic                 busy
);

    localparam bit PAR_EN  = (PARITY_BIT != PARITY_NONE);
    localparam bit PAR_ODD = (PARITY_BIT == PARITY_ODD);
    localparam int BW      = 4;
    localparam int PW      = (CLKS_PER_BIT <= 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [PW-1:0] HOLD_INIT = PW'(CLKS_PER_BIT - 1);

    uart_rx_state_e        state;
    logic [BW-1:0]         bit_cnt;
    logic [PW-1:0]         hold_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  all_zero;
    logic                  stop_err;
    logic                  par_err;
    logic                  armed;
    logic [1:0]            settle;

    logic rx_sync;
    logic sample_stb;
    logic sample_bit;
    logic phase_wrap;
    logic restart;

    // A start is only accepted once the line has been seen high after reset,
    // so a frame already in flight at reset release is ignored.
    assign restart = (state == ST_IDLE) && armed && !rx_sync;
    assign busy    = (state != ST_IDLE);

    uart_rx_sampler #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .restart    (restart),
        .rx_sync    (rx_sync),
        .sample_stb (sample_stb),
        .sample_bit (sample_bit),
        .phase_wrap (phase_wrap)
    );

    // Frame FSM, holding register handshake and one-cycle status pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            hold_cnt    <= '0;
            shreg       <= '0;
            all_zero    <= 1'b0;
            stop_err    <= 1'b0;
            par_err     <= 1'b0;
            armed       <= 1'b0;
            settle      <= 2'b00;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            rx_break    <= 1'b0;
        end else begin
            err_parity  <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
            rx_break    <= 1'b0;

            // settle[1] marks that the synchroniser now reflects the real line.
            settle <= {settle[0], 1'b1};
            if (settle[1] && rx_sync) armed <= 1'b1;

            if (rx_valid && rx_ready) rx_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (restart) begin
                        state    <= ST_START;
                        bit_cnt  <= '0;
                        all_zero <= 1'b1;
                        stop_err <= 1'b0;
                        par_err  <= 1'b0;
                    end
                end

                ST_START: begin
                    if (sample_stb && sample_bit) begin
                        state <= ST_IDLE;
                    end else if (phase_wrap) begin
                        state   <= ST_DATA;
                        bit_cnt <= '0;
                    end
                end

                ST_DATA: begin
                    if (sample_stb) begin
                        shreg <= {sample_bit, shreg[DATA_BITS-1:1]};
                        if (sample_bit) all_zero <= 1'b0;
                    end
                    if (phase_wrap) begin
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= PAR_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (sample_stb) begin
                        par_err <= (sample_bit != parity_expected(^shreg, PAR_ODD));
                        if (sample_bit) all_zero <= 1'b0;
                    end
                    if (phase_wrap) state <= ST_STOP;
                end

                ST_STOP: begin
                    if (sample_stb) begin
                        if (!sample_bit) stop_err <= 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            // Last stop bit decided: resolve the frame now.
                            state <= ST_IDLE;
                            if (all_zero && !sample_bit) begin
                                rx_break <= 1'b1;
                                state    <= ST_BREAK_WAIT;
                                hold_cnt <= HOLD_INIT;
                            end else if (stop_err || !sample_bit) begin
                                err_frame <= 1'b1;
                            end else if (par_err) begin
                                err_parity <= 1'b1;
                            end else if (!rx_valid || rx_ready) begin
                                rx_data  <= shreg;
                                rx_valid <= 1'b1;
                            end else begin
                                err_overrun <= 1'b1;
                            end
                        end
                    end else if (phase_wrap) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end

                ST_BREAK_WAIT: begin
                    if (!rx_sync) begin
                        hold_cnt <= HOLD_INIT;
                    end else if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: 8N1, 8E1 and 8N2 instances share
// one driven line, routed to the instance selected by sel.
module tb_uart_rx_oversampled;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic line;
    int   sel;

    logic       rx_a, rx_b, rx_c;
    logic [7:0] data_a, data_b, data_c;
    logic       valid_a, valid_b, valid_c;
    logic       rdy_a, rdy_b, rdy_c;
    logic       perr_a, perr_b, perr_c;
    logic       ferr_a, ferr_b, ferr_c;
    logic       oerr_a, oerr_b, oerr_c;
    logic       brk_a, brk_b, brk_c;
    logic       busy_a, busy_b, busy_c;

    assign rx_a = (sel == 0) ? line : 1'b1;
    assign rx_b = (sel == 1) ? line : 1'b1;
    assign rx_c = (sel == 2) ? line : 1'b1;

    uart_rx_oversampled #(.DATA_BITS(8), .PARITY_BIT("none"), .STOP_BITS(1), .CLKS_PER_BIT(16)) u_n1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_a), .rx_data(data_a), .rx_valid(valid_a),
        .rx_ready(rdy_a), .err_parity(perr_a), .err_frame(ferr_a),
        .err_overrun(oerr_a), .rx_break(brk_a), .busy(busy_a));

    uart_rx_oversampled #(.DATA_BITS(8), .PARITY_BIT("even"), .STOP_BITS(1), .CLKS_PER_BIT(16)) u_e1 (
        .clk(clk), .rst_n(rst_n), .rx(rx_b), .rx_data(data_b), .rx_valid(valid_b),
        .rx_ready(rdy_b), .err_parity(perr_b), .err_frame(ferr_b),
        .err_overrun(oerr_b), .rx_break(brk_b), .busy(busy_b));

    uart_rx_oversampled #(.DATA_BITS(8), .PARITY_BIT("none"), .STOP_BITS(2), .CLKS_PER_BIT(16)) u_n2 (
        .clk(clk), .rst_n(rst_n), .rx(rx_c), .rx_data(data_c), .rx_valid(valid_c),
        .rx_ready(rdy_c), .err_parity(perr_c), .err_frame(ferr_c),
        .err_overrun(oerr_c), .rx_break(brk_c), .busy(busy_c));

    int tests_run    = 0;
    int tests_failed = 0;

    // Pulse counters per instance, sampled mid-cycle.
    int cnt_par[3], cnt_frm[3], cnt_ovr[3], cnt_brk[3];
    int base_par[3], base_frm[3], base_ovr[3], base_brk[3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            cnt_par[i] = 0; cnt_frm[i] = 0; cnt_ovr[i] = 0; cnt_brk[i] = 0;
        end
    end

    always @(negedge clk) begin
        cnt_par[0] += int'(perr_a); cnt_frm[0] += int'(ferr_a); cnt_ovr[0] += int'(oerr_a); cnt_brk[0] += int'(brk_a);
        cnt_par[1] += int'(perr_b); cnt_frm[1] += int'(ferr_b); cnt_ovr[1] += int'(oerr_b); cnt_brk[1] += int'(brk_b);
        cnt_par[2] += int'(perr_c); cnt_frm[2] += int'(ferr_c); cnt_ovr[2] += int'(oerr_c); cnt_brk[2] += int'(brk_c);
    end

    task automatic chk(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic snap();
        for (int i = 0; i < 3; i++) begin
            base_par[i] = cnt_par[i]; base_frm[i] = cnt_frm[i];
            base_ovr[i] = cnt_ovr[i]; base_brk[i] = cnt_brk[i];
        end
    endtask

    function automatic logic busy_of(input int s);
        case (s)
            0:       return busy_a;
            1:       return busy_b;
            default: return busy_c;
        endcase
    endfunction

    // Drives n line bits, LSB first, 16 clocks each; line returns high after.
    task automatic send_bits(input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            line = bits[i];
            repeat (16) @(posedge clk);
            #1;
        end
        line = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input int with_par, input logic par,
                              input int nstop, input logic stop2);
        logic [11:0] b;
        int          n;
        b      = '1;
        b[0]   = 1'b0;
        b[8:1] = d;
        n      = 9;
        if (with_par != 0) begin
            b[n] = par;
            n++;
        end
        b[n] = 1'b1;
        n++;
        if (nstop == 2) begin
            b[n] = stop2;
            n++;
        end
        send_bits(b, n);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy_of(sel) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= 300) chk({tag, "_idle_timeout"}, 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        logic seen;

        rst_n = 1'b0;
        line  = 1'b1;
        sel   = 0;
        rdy_a = 1'b0; rdy_b = 1'b0; rdy_c = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data",  int'(data_a), 0);
        chk("rst_flags", int'({valid_a, perr_a, ferr_a, oerr_a, brk_a, busy_a}), 0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8N1 0xA5 held for 100 cycles, then handshake.
        snap();
        sel = 0;
        send_frame(8'hA5, 0, 1'b0, 1, 1'b1);
        wait_idle("a5");
        repeat (100) @(posedge clk);
        #1;
        chk("a5_data",  int'(data_a), 8'hA5);
        chk("a5_valid", int'(valid_a), 1);
        chk("a5_flags", (cnt_par[0]-base_par[0]) + (cnt_frm[0]-base_frm[0]) +
                        (cnt_ovr[0]-base_ovr[0]) + (cnt_brk[0]-base_brk[0]), 0);
        rdy_a = 1'b1;
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
        chk("a5_valid_cleared", int'(valid_a), 0);
        chk("a5_data_kept",     int'(data_a), 8'hA5);

        // 8E1 0x3C: wrong parity (1) then correct parity (0).
        snap();
        sel = 1;
        send_frame(8'h3C, 1, 1'b1, 1, 1'b1);
        wait_idle("par_bad");
        repeat (4) @(posedge clk);
        #1;
        chk("par_bad_pulse", cnt_par[1]-base_par[1], 1);
        chk("par_bad_valid", int'(valid_b), 0);
        chk("par_bad_frame", cnt_frm[1]-base_frm[1], 0);
        send_frame(8'h3C, 1, 1'b0, 1, 1'b1);
        wait_idle("par_good");
        repeat (4) @(posedge clk);
        #1;
        chk("par_good_data",  int'(data_b), 8'h3C);
        chk("par_good_valid", int'(valid_b), 1);
        chk("par_good_nopulse", cnt_par[1]-base_par[1], 1);

        // 8N2 0x55 with the second stop bit low.
        snap();
        sel = 2;
        send_frame(8'h55, 0, 1'b0, 2, 1'b0);
        wait_idle("frm");
        repeat (4) @(posedge clk);
        #1;
        chk("frm_pulse",  cnt_frm[2]-base_frm[2], 1);
        chk("frm_valid",  int'(valid_c), 0);
        chk("frm_others", (cnt_par[2]-base_par[2]) + (cnt_ovr[2]-base_ovr[2]) + (cnt_brk[2]-base_brk[2]), 0);

        // 3-cycle glitch on idle line.
        snap();
        sel = 0;
        repeat (20) @(posedge clk);
        #1;
        line = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        line = 1'b1;
        seen = busy_a;
        n = 0;
        while (n < 20 && !(seen && !busy_a)) begin
            @(posedge clk);
            #1;
            n++;
            if (busy_a) seen = 1'b1;
        end
        chk("glitch_busy_seen", int'(seen), 1);
        chk("glitch_idle_12",   int'(n <= 12), 1);
        repeat (30) @(posedge clk);
        #1;
        chk("glitch_valid", int'(valid_a), 0);
        chk("glitch_flags", (cnt_par[0]-base_par[0]) + (cnt_frm[0]-base_frm[0]) +
                            (cnt_ovr[0]-base_ovr[0]) + (cnt_brk[0]-base_brk[0]), 0);

        // Overrun: 0x11 held, 0x22 dropped, then 0x33 with ready high.
        snap();
        send_frame(8'h11, 0, 1'b0, 1, 1'b1);
        wait_idle("ovr1");
        send_frame(8'h22, 0, 1'b0, 1, 1'b1);
        wait_idle("ovr2");
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_data",  int'(data_a), 8'h11);
        chk("ovr_valid", int'(valid_a), 1);
        chk("ovr_pulse", cnt_ovr[0]-base_ovr[0], 1);
        rdy_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send_frame(8'h33, 0, 1'b0, 1, 1'b1);
        wait_idle("ovr3");
        repeat (4) @(posedge clk);
        #1;
        chk("ovr_new_data", int'(data_a), 8'h33);
        chk("ovr_once",     cnt_ovr[0]-base_ovr[0], 1);
        rdy_a = 1'b0;

        // Break: 12 bit times low.
        snap();
        line = 1'b0;
        repeat (12 * 16) @(posedge clk);
        #1;
        line = 1'b1;
        wait_idle("brk");
        repeat (20) @(posedge clk);
        #1;
        chk("brk_pulse", cnt_brk[0]-base_brk[0], 1);
        chk("brk_frame", cnt_frm[0]-base_frm[0], 0);
        chk("brk_valid", int'(valid_a), 0);
        chk("brk_idle",  int'(busy_a), 0);

        // Reset mid-frame with the line low, then 0x81.
        line = 1'b0;
        repeat (16) @(posedge clk);
        #1;
        line = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        line = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("mid_busy", int'(busy_a), 1);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_data",  int'(data_a), 0);
        chk("mid_rst_flags", int'({valid_a, perr_a, ferr_a, oerr_a, brk_a, busy_a}), 0);
        rst_n = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        chk("post_rst_low_ignored", int'(busy_a), 0);
        line = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        snap();
        send_frame(8'h81, 0, 1'b0, 1, 1'b1);
        wait_idle("r81");
        repeat (4) @(posedge clk);
        #1;
        chk("r81_data",  int'(data_a), 8'h81);
        chk("r81_valid", int'(valid_a), 1);
        chk("r81_flags", (cnt_par[0]-base_par[0]) + (cnt_frm[0]-base_frm[0]) +
                         (cnt_ovr[0]-base_ovr[0]) + (cnt_brk[0]-base_brk[0]), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
